tdm_demux_1x4: RTL and testbench
================================

Name: tdm_demux_1x4

Overview:
Receive end of the team's 4-channel selector path. A serial time-division stream carries one word per slot across four slots per frame, with slot 0 flagged by a frame-sync strobe. The block rebuilds each frame into four parallel registered outputs Y0..Y3 and publishes them atomically once the frame is complete. It also tracks framing lock and counts sync errors.

Parameters:
DW, 8, data width of each slot word and each output channel
ERR_W, 4, width of saturating sync-error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
din  input  DW  slot word from serial stream
din_valid  input  1  din is valid this cycle; no backpressure
fsync  input  1  frame sync, qualifies din as slot 0; ignored when din_valid=0
Y0  output  DW  channel 0 word of last complete frame
Y1  output  DW  channel 1 word of last complete frame
Y2  output  DW  channel 2 word of last complete frame
Y3  output  DW  channel 3 word of last complete frame
frame_valid  output  1  one-cycle pulse: Y0..Y3 just updated
slot  output  2  slot index expected for next valid word
locked  output  1  1 when in LOCKED state
sync_err  output  1  one-cycle pulse on framing violation
err_count  output  ERR_W  saturating count of sync_err pulses

Behaviour:
- Reset (rst_n=0 at a clk edge) sets Y0..Y3=0, frame_valid=0, slot=0, locked=0, sync_err=0, err_count=0, staging registers=0, state=HUNT. Reset wins over all other inputs, including mid-frame. A partial frame is discarded.
- Two states: HUNT and LOCKED. Cycles with din_valid=0 change nothing, except that pulse outputs return to 0.
- HUNT with din_valid=1, fsync=1: store din in stage0, set slot=1, go to LOCKED.
- HUNT with din_valid=1, fsync=0: drop the word. No error is flagged, because hunting is not a violation.
- LOCKED with din_valid=1 and fsync=0:
  - slot=1 or 2: store the word in stage1 or stage2, slot+1.
  - slot=3: on the next edge, Y0=stage0, Y1=stage1, Y2=stage2, Y3=din, frame_valid=1, slot=0. Latency is one cycle from acceptance of the slot-3 word.
  - slot=0: violation, a missing fsync. sync_err=1, drop the word, go to HUNT, slot=0.
- LOCKED with din_valid=1 and fsync=1:
  - slot=0: normal start of frame. Store in stage0, slot=1.
  - slot=1..3: violation, an early fsync. sync_err=1, discard the partial frame, treat this word as the new slot 0 (store in stage0, slot=1), stay LOCKED. Y0..Y3 are not updated and frame_valid stays 0.
- Y0..Y3 hold their value between frame_valid pulses. Outputs never expose a partial frame.
- err_count increments on each sync_err. It saturates at 2^ERR_W-1 with no wrap.
- frame_valid and sync_err can never both be 1 in the same cycle.
- Back-to-back frames with din_valid held high give one frame_valid every 4 cycles.
- locked reflects the state register directly, with no extra latency.

Test Plan:
- Reset, then 4 consecutive valid words 8'hA1 (fsync=1), 8'hB2, 8'hC3, 8'hD4 -> one cycle after D4, frame_valid=1 and Y0..Y3=A1,B2,C3,D4; locked=1; slot=0; sync_err never 1.
- Same frame with din_valid=0 gaps of 1–3 cycles between words -> identical outputs; frame_valid pulses exactly once, one cycle after D4.
- Locked, send 8'h11 (fsync), 8'h22, then 8'h33 with fsync=1, then 8'h44, 8'h55, 8'h66 -> sync_err pulses on the cycle after 33; next frame_valid gives Y0..Y3=33,44,55,66; earlier Y values held until then.
- After a complete frame, send a valid word with fsync=0 -> sync_err=1, locked=0, err_count=1; the following non-fsync words are dropped silently with no further errors; the next fsync word relocks.
- Assert rst_n=0 after 2 words of a frame, then release -> all outputs 0, locked=0; the remaining 2 words without fsync produce no frame_valid.
- Force 20 missing-fsync violations with ERR_W=4 -> err_count saturates at 15 and stays there.

Source files
------------

// File: rtl/tdm_demux_1x4.sv
// ============================================================================
// Module  : tdm_demux_1x4
// Brief   : Rebuilds a 4-slot TDM stream into atomically published parallel
//           channels, with framing lock tracking and a sync-error counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tdm_demux_1x4 #(
  parameter int DW    = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [DW-1:0]    Y0,
  output logic [DW-1:0]    Y1,
  output logic [DW-1:0]    Y2,
  output logic [DW-1:0]    Y3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           r_state,  w_state;
  logic [1:0]       r_slot,   w_slot;
  logic [DW-1:0]    r_stage0, w_stage0;
  logic [DW-1:0]    r_stage1, w_stage1;
  logic [DW-1:0]    r_stage2, w_stage2;
  logic [DW-1:0]    r_y0, r_y1, r_y2, r_y3;
  logic [DW-1:0]    w_y0, w_y1, w_y2, w_y3;
  logic             r_fv,     w_fv;
  logic             r_serr,   w_serr;
  logic [ERR_W-1:0] r_err,    w_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_HUNT;
      r_slot   <= 2'd0;
      r_stage0 <= '0;
      r_stage1 <= '0;
      r_stage2 <= '0;
      r_y0     <= '0;
      r_y1     <= '0;
      r_y2     <= '0;
      r_y3     <= '0;
      r_fv     <= 1'b0;
      r_serr   <= 1'b0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state;
      r_slot   <= w_slot;
      r_stage0 <= w_stage0;
      r_stage1 <= w_stage1;
      r_stage2 <= w_stage2;
      r_y0     <= w_y0;
      r_y1     <= w_y1;
      r_y2     <= w_y2;
      r_y3     <= w_y3;
      r_fv     <= w_fv;
      r_serr   <= w_serr;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_slot   = r_slot;
    w_stage0 = r_stage0;
    w_stage1 = r_stage1;
    w_stage2 = r_stage2;
    w_y0     = r_y0;
    w_y1     = r_y1;
    w_y2     = r_y2;
    w_y3     = r_y3;
    w_fv     = 1'b0;
    w_serr   = 1'b0;
    w_err    = r_err;

    if (din_valid) begin
      if (r_state == S_HUNT) begin
        if (fsync) begin
          w_stage0 = din;
          w_slot   = 2'd1;
          w_state  = S_LOCKED;
        end
      end else if (fsync) begin
        // An fsync mid-frame restarts the frame on this word.
        w_serr   = (r_slot != 2'd0);
        w_stage0 = din;
        w_slot   = 2'd1;
      end else begin
        case (r_slot)
          2'd0: begin
            w_serr  = 1'b1;
            w_state = S_HUNT;
          end
          2'd1: begin
            w_stage1 = din;
            w_slot   = 2'd2;
          end
          2'd2: begin
            w_stage2 = din;
            w_slot   = 2'd3;
          end
          default: begin
            w_y0   = r_stage0;
            w_y1   = r_stage1;
            w_y2   = r_stage2;
            w_y3   = din;
            w_fv   = 1'b1;
            w_slot = 2'd0;
          end
        endcase
      end
    end

    if (w_serr && (r_err != c_ERR_MAX)) begin
      w_err = r_err + c_ERR_ONE;
    end
  end

  assign Y0          = r_y0;
  assign Y1          = r_y1;
  assign Y2          = r_y2;
  assign Y3          = r_y3;
  assign frame_valid = r_fv;
  assign slot        = r_slot;
  assign locked      = (r_state == S_LOCKED);
  assign sync_err    = r_serr;
  assign err_count   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_1x4.sv
// ============================================================================
// Module  : tb_tdm_demux_1x4
// Brief   : Directed plus random stimulus against a queue-based frame model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tdm_demux_1x4;

  localparam int DW    = 8;
  localparam int ERR_W = 4;

  logic             clk;
  logic             rst_n;
  logic [DW-1:0]    din;
  logic             din_valid;
  logic             fsync;
  logic [DW-1:0]    Y0, Y1, Y2, Y3;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;
  logic [ERR_W-1:0] err_count;

  tdm_demux_1x4 #(.DW(DW), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .fsync       (fsync),
    .Y0          (Y0),
    .Y1          (Y1),
    .Y2          (Y2),
    .Y3          (Y3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: a frame is the list of words collected since the last fsync.
  logic [DW-1:0] m_part[$];
  logic [DW-1:0] m_y[4];
  bit            m_locked;
  bit            m_fv;
  bit            m_se;
  int            m_err;
  int            fv_seen;
  int            se_seen;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("Y0", int'(Y0), int'(m_y[0]));
    chk("Y1", int'(Y1), int'(m_y[1]));
    chk("Y2", int'(Y2), int'(m_y[2]));
    chk("Y3", int'(Y3), int'(m_y[3]));
    chk("frame_valid", int'(frame_valid), int'(m_fv));
    chk("sync_err", int'(sync_err), int'(m_se));
    chk("locked", int'(locked), int'(m_locked));
    chk("slot", int'(slot), m_part.size());
    chk("err_count", int'(err_count), m_err);
    if (frame_valid === 1'b1) fv_seen++;
    if (sync_err === 1'b1) se_seen++;
  endtask

  task automatic model_step(input bit v, input bit fs, input logic [DW-1:0] d);
    bit err;
    err  = 1'b0;
    m_fv = 1'b0;
    if (v) begin
      if (fs) begin
        if (m_locked && m_part.size() != 0) err = 1'b1;
        m_part.delete();
        m_part.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_part.size() == 0) begin
          err      = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_part.push_back(d);
          if (m_part.size() == 4) begin
            for (int i = 0; i < 4; i++) m_y[i] = m_part[i];
            m_part.delete();
            m_fv = 1'b1;
          end
        end
      end
    end
    m_se = err;
    if (err && m_err < (1 << ERR_W) - 1) m_err++;
  endtask

  task automatic step(input bit v, input bit fs, input logic [DW-1:0] d);
    @(negedge clk);
    din_valid = v;
    fsync     = fs;
    din       = d;
    @(posedge clk);
    #1;
    model_step(v, fs, d);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b1;
    fsync     = 1'b1;
    din       = 8'h5A;
    @(posedge clk);
    #1;
    m_part.delete();
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    m_locked = 1'b0;
    m_fv     = 1'b0;
    m_se     = 1'b0;
    m_err    = 0;
    check_all();
    @(negedge clk);
    rst_n     = 1'b1;
    din_valid = 1'b0;
    fsync     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    fsync     = 1'b0;
    din       = '0;
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    m_locked = 1'b0;
    m_err    = 0;
    fv_seen  = 0;
    se_seen  = 0;

    // Basic frame, back to back
    do_reset();
    step(1, 1, 8'hA1);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hC3);
    step(1, 0, 8'hD4);
    chk("basic_frame_pulses", fv_seen, 1);
    chk("basic_no_sync_err", se_seen, 0);

    // Same frame with idle gaps
    fv_seen = 0;
    step(1, 1, 8'hA1); idle(int'($urandom_range(1, 3)));
    step(1, 0, 8'hB2); idle(int'($urandom_range(1, 3)));
    step(1, 0, 8'hC3); idle(int'($urandom_range(1, 3)));
    step(1, 0, 8'hD4); idle(3);
    chk("gapped_frame_pulses", fv_seen, 1);

    // Early fsync restarts the frame
    step(1, 1, 8'h11);
    step(1, 0, 8'h22);
    step(1, 1, 8'h33);
    step(1, 0, 8'h44);
    step(1, 0, 8'h55);
    step(1, 0, 8'h66);

    // Missing fsync drops lock; following words ignored until fsync
    se_seen = 0;
    step(1, 0, 8'h77);
    step(1, 0, 8'h78);
    step(1, 0, 8'h79);
    chk("hunt_single_error", se_seen, 1);
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(1, 0, 8'h03);
    step(1, 0, 8'h04);

    // Reset mid-frame discards the partial frame
    step(1, 1, 8'hE1);
    step(1, 0, 8'hE2);
    do_reset();
    fv_seen = 0;
    step(1, 0, 8'hE3);
    step(1, 0, 8'hE4);
    chk("post_reset_no_frame", fv_seen, 0);

    // Error counter saturation
    for (int i = 0; i < 20; i++) begin
      step(1, 1, DW'(i));
      step(1, 0, DW'(i + 100));
    end
    chk("err_saturated", int'(err_count), 15);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), DW'($urandom));
    end

    // Clean back-to-back frames
    fv_seen = 0;
    for (int f = 0; f < 5; f++) begin
      for (int s = 0; s < 4; s++) step(1, (s == 0), DW'($urandom));
    end
    chk("b2b_frames", fv_seen, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
